// File: rtl/core_pkg.sv
// core_pkg: shared core widths, reservation-station entry types and CDB wakeup helper
package core_pkg;
    localparam int ALLOC_W     = 2;
    localparam int ISSUE_WIDTH = 2;
    localparam int RS_ENTRIES  = 16;
    localparam int CDB_W       = 2;
    localparam int PHYS_W      = 6;
    localparam int XLEN        = 32;
    localparam int VAL_W       = 64;
    localparam int ROB_W       = 6;

    typedef struct packed {
        logic [PHYS_W-1:0] tag;
        logic [VAL_W-1:0]  val;
        logic              rdy;
    } rs_src_t;

    typedef struct packed {
        logic              valid;
        logic [7:0]        op;
        logic [PHYS_W-1:0] dst;
        logic [ROB_W-1:0]  rob;
        rs_src_t           src1;
        rs_src_t           src2;
    } rs_entry_t;

    // Later CDB ports override earlier ones when tags collide.
    function automatic rs_src_t wake(
        input rs_src_t                        s,
        input logic [CDB_W-1:0]               v,
        input logic [CDB_W-1:0][PHYS_W-1:0]   t,
        input logic [CDB_W-1:0][XLEN-1:0]     d
    );
        rs_src_t r;
        r = s;
        for (int k = 0; k < CDB_W; k++)
            if (!s.rdy && v[k] && t[k] == s.tag) begin
                r.rdy = 1'b1;
                r.val = {{(VAL_W-XLEN){1'b0}}, d[k]};
            end
        return r;
    endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: picks up to W oldest eligible entries from an age matrix, one-hot per lane
module rs_age_select #(
    parameter int N = 16,
    parameter int W = 2
) (
    input  logic [N-1:0][N-1:0] age_i,
    input  logic [N-1:0]        elig_i,
    output logic [W-1:0][N-1:0] pick_o,
    output logic [W-1:0]        valid_o
);
    logic [N-1:0][N-1:0] older;
    logic [W:0][N-1:0]   rem;
    logic [W-1:0][N-1:0] cand;

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                older[i][j] = age_i[j][i];
    end

    always_comb begin
        rem[0] = elig_i;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < N; i++)
                cand[l][i] = rem[l][i] && !(|(rem[l] & older[i]));
            pick_o[l]  = cand[l] & -cand[l];
            valid_o[l] = |cand[l];
            rem[l+1]   = rem[l] & ~pick_o[l];
        end
    end
endmodule

// File: rtl/rs_alu.sv
// rs_alu: unified ALU/branch reservation station with CDB wakeup and oldest-first dual issue
module rs_alu
    import core_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [ALLOC_W-1:0]                 alloc_en,
    input  logic [ALLOC_W-1:0][PHYS_W-1:0]     alloc_dst_tag,
    input  logic [ALLOC_W-1:0][PHYS_W-1:0]     alloc_src1_tag,
    input  logic [ALLOC_W-1:0][PHYS_W-1:0]     alloc_src2_tag,
    input  logic [ALLOC_W-1:0][VAL_W-1:0]      alloc_src1_val,
    input  logic [ALLOC_W-1:0][VAL_W-1:0]      alloc_src2_val,
    input  logic [ALLOC_W-1:0]                 alloc_src1_ready,
    input  logic [ALLOC_W-1:0]                 alloc_src2_ready,
    input  logic [ALLOC_W-1:0][7:0]            alloc_op,
    input  logic [ALLOC_W-1:0][ROB_W-1:0]      alloc_rob_tag,
    output logic                               rs_full,
    input  logic [CDB_W-1:0]                   cdb_valid,
    input  logic [CDB_W-1:0][PHYS_W-1:0]       cdb_tag,
    input  logic [CDB_W-1:0][XLEN-1:0]         cdb_value,
    output logic [ISSUE_WIDTH-1:0]             issue_valid,
    input  logic [ISSUE_WIDTH-1:0]             issue_ready,
    output logic [ISSUE_WIDTH-1:0][7:0]        issue_op,
    output logic [ISSUE_WIDTH-1:0][VAL_W-1:0]  issue_src1_val,
    output logic [ISSUE_WIDTH-1:0][VAL_W-1:0]  issue_src2_val,
    output logic [ISSUE_WIDTH-1:0][PHYS_W-1:0] issue_dst_tag,
    output logic [ISSUE_WIDTH-1:0][ROB_W-1:0]  issue_rob_tag
);
    localparam int N = RS_ENTRIES;

    rs_entry_t                     ent_q [N];
    rs_entry_t                     ent_d [N];
    rs_entry_t [ALLOC_W-1:0]       new_ent;
    logic [N-1:0][N-1:0]           age_q, age_d;
    logic                          rs_full_q, rs_full_d;
    logic [N-1:0]                  valid_q, valid_d, elig, keep, issued;
    logic [ALLOC_W-1:0][N-1:0]     slot;
    logic [ALLOC_W-1:0]            alloc_go;
    logic [ISSUE_WIDTH-1:0][N-1:0] pick;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            valid_q[i] = ent_q[i].valid;
            elig[i]    = ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
        end
    end

    // Slots come from the registered valid vector, so slots freed this cycle stay unused.
    always_comb begin
        logic [N-1:0] free;
        free = ~valid_q;
        for (int l = 0; l < ALLOC_W; l++) begin
            slot[l]           = free & -free;
            free              = free & ~slot[l];
            alloc_go[l]       = alloc_en[l] && !rs_full_q && !flush;
            new_ent[l].valid  = 1'b1;
            new_ent[l].op     = alloc_op[l];
            new_ent[l].dst    = alloc_dst_tag[l];
            new_ent[l].rob    = alloc_rob_tag[l];
            new_ent[l].src1   = wake(rs_src_t'{alloc_src1_tag[l], alloc_src1_val[l], alloc_src1_ready[l]},
                                     cdb_valid, cdb_tag, cdb_value);
            new_ent[l].src2   = wake(rs_src_t'{alloc_src2_tag[l], alloc_src2_val[l], alloc_src2_ready[l]},
                                     cdb_valid, cdb_tag, cdb_value);
        end
    end

    rs_age_select #(.N(N), .W(ISSUE_WIDTH)) u_sel (
        .age_i   (age_q),
        .elig_i  (elig),
        .pick_o  (pick),
        .valid_o (issue_valid)
    );

    always_comb begin
        issued         = '0;
        issue_op       = '0;
        issue_src1_val = '0;
        issue_src2_val = '0;
        issue_dst_tag  = '0;
        issue_rob_tag  = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            issued = issued | (pick[l] & {N{issue_valid[l] && issue_ready[l]}});
            for (int i = 0; i < N; i++)
                if (pick[l][i]) begin
                    issue_op[l]       = ent_q[i].op;
                    issue_src1_val[l] = ent_q[i].src1.val;
                    issue_src2_val[l] = ent_q[i].src2.val;
                    issue_dst_tag[l]  = ent_q[i].dst;
                    issue_rob_tag[l]  = ent_q[i].rob;
                end
        end
    end

    always_comb begin
        logic [N-1:0] prev;
        prev = '0;
        keep = valid_q & ~issued;
        for (int i = 0; i < N; i++) begin
            ent_d[i]       = ent_q[i];
            ent_d[i].valid = keep[i] && !flush;
            ent_d[i].src1  = wake(ent_q[i].src1, cdb_valid, cdb_tag, cdb_value);
            ent_d[i].src2  = wake(ent_q[i].src2, cdb_valid, cdb_tag, cdb_value);
            for (int j = 0; j < N; j++)
                age_d[i][j] = age_q[i][j] && keep[i] && keep[j] && !flush;
        end
        // Survivors and earlier lanes of this cycle are older than each newcomer.
        for (int l = 0; l < ALLOC_W; l++)
            if (alloc_go[l]) begin
                for (int i = 0; i < N; i++)
                    if (slot[l][i]) begin
                        ent_d[i] = new_ent[l];
                        for (int j = 0; j < N; j++)
                            age_d[j][i] = keep[j] || prev[j];
                    end
                prev = prev | slot[l];
            end
        for (int i = 0; i < N; i++)
            valid_d[i] = ent_d[i].valid;
        rs_full_d = $countones(~valid_d) < ALLOC_W;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q     <= '{default: '0};
            age_q     <= '0;
            rs_full_q <= 1'b0;
        end else begin
            ent_q     <= ent_d;
            age_q     <= age_d;
            rs_full_q <= rs_full_d;
        end
    end

    assign rs_full = rs_full_q;

    a_no_alloc_when_full: assert property (@(posedge clk) disable iff (reset) !(rs_full_q && |alloc_en));
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed scoreboard bench for rs_alu
module tb_rs_alu;
    import core_pkg::*;

    logic                               clk = 1'b0;
    logic                               reset, flush;
    logic [ALLOC_W-1:0]                 alloc_en;
    logic [ALLOC_W-1:0][PHYS_W-1:0]     alloc_dst_tag, alloc_src1_tag, alloc_src2_tag;
    logic [ALLOC_W-1:0][VAL_W-1:0]      alloc_src1_val, alloc_src2_val;
    logic [ALLOC_W-1:0]                 alloc_src1_ready, alloc_src2_ready;
    logic [ALLOC_W-1:0][7:0]            alloc_op;
    logic [ALLOC_W-1:0][ROB_W-1:0]      alloc_rob_tag;
    logic                               rs_full;
    logic [CDB_W-1:0]                   cdb_valid;
    logic [CDB_W-1:0][PHYS_W-1:0]       cdb_tag;
    logic [CDB_W-1:0][XLEN-1:0]         cdb_value;
    logic [ISSUE_WIDTH-1:0]             issue_valid, issue_ready;
    logic [ISSUE_WIDTH-1:0][7:0]        issue_op;
    logic [ISSUE_WIDTH-1:0][VAL_W-1:0]  issue_src1_val, issue_src2_val;
    logic [ISSUE_WIDTH-1:0][PHYS_W-1:0] issue_dst_tag;
    logic [ISSUE_WIDTH-1:0][ROB_W-1:0]  issue_rob_tag;

    typedef struct packed {
        logic              lane;
        logic [7:0]        op;
        logic [VAL_W-1:0]  s1;
        logic [VAL_W-1:0]  s2;
        logic [PHYS_W-1:0] dst;
        logic [ROB_W-1:0]  rob;
    } exp_t;

    exp_t q[$];
    exp_t e_act, e_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rs_alu dut (
        .clk(clk), .reset(reset), .flush(flush), .alloc_en(alloc_en),
        .alloc_dst_tag(alloc_dst_tag), .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_src1_val(alloc_src1_val), .alloc_src2_val(alloc_src2_val),
        .alloc_src1_ready(alloc_src1_ready), .alloc_src2_ready(alloc_src2_ready),
        .alloc_op(alloc_op), .alloc_rob_tag(alloc_rob_tag), .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
        .issue_dst_tag(issue_dst_tag), .issue_rob_tag(issue_rob_tag)
    );

    always @(negedge clk)
        if (!reset)
            for (int l = 0; l < ISSUE_WIDTH; l++)
                if (issue_valid[l] && issue_ready[l]) begin
                    e_act = {l[0], issue_op[l], issue_src1_val[l], issue_src2_val[l], issue_dst_tag[l], issue_rob_tag[l]};
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL issue: unexpected issue got %h expected none", e_act);
                    end else begin
                        e_exp = q.pop_front();
                        if (e_act !== e_exp) begin
                            errors++;
                            $display("FAIL issue lane%0d: got %h expected %h", l, e_act, e_exp);
                        end
                    end
                end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_en  = '0;
        cdb_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic alloc(input int l, input logic [7:0] op, input logic [PHYS_W-1:0] dst, input logic [ROB_W-1:0] rob,
                         input logic [PHYS_W-1:0] t1, input logic r1, input logic [VAL_W-1:0] v1,
                         input logic [PHYS_W-1:0] t2, input logic r2, input logic [VAL_W-1:0] v2);
        alloc_en[l]         = 1'b1;
        alloc_op[l]         = op;
        alloc_dst_tag[l]    = dst;
        alloc_rob_tag[l]    = rob;
        alloc_src1_tag[l]   = t1;
        alloc_src1_ready[l] = r1;
        alloc_src1_val[l]   = v1;
        alloc_src2_tag[l]   = t2;
        alloc_src2_ready[l] = r2;
        alloc_src2_val[l]   = v2;
    endtask

    task automatic cdb(input int k, input logic [PHYS_W-1:0] t, input logic [XLEN-1:0] v);
        cdb_valid[k] = 1'b1;
        cdb_tag[k]   = t;
        cdb_value[k] = v;
    endtask

    task automatic push(input logic lane, input logic [7:0] op, input logic [VAL_W-1:0] s1, input logic [VAL_W-1:0] s2,
                        input logic [PHYS_W-1:0] dst, input logic [ROB_W-1:0] rob);
        exp_t x;
        x = {lane, op, s1, s2, dst, rob};
        q.push_back(x);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; alloc_en = '0; cdb_valid = '0; issue_ready = 2'b11;
        alloc_dst_tag = '0; alloc_src1_tag = '0; alloc_src2_tag = '0; alloc_src1_val = '0; alloc_src2_val = '0;
        alloc_src1_ready = '0; alloc_src2_ready = '0; alloc_op = '0; alloc_rob_tag = '0; cdb_tag = '0; cdb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_full", rs_full, 0);
        chk("reset_valid", issue_valid, 0);
        chk("reset_outs", {issue_op, issue_dst_tag, issue_rob_tag}, 0);
        chk("reset_vals", |{issue_src1_val, issue_src2_val}, 0);
        reset = 1'b0;
        tick();

        // two ready ops issue together the next cycle
        alloc(0, 8'h11, 6'd5, 6'd1, 6'd1, 1'b1, 64'h10, 6'd2, 1'b1, 64'h20);
        alloc(1, 8'h12, 6'd6, 6'd2, 6'd3, 1'b1, 64'h30, 6'd4, 1'b1, 64'h40);
        push(1'b0, 8'h11, 64'h10, 64'h20, 6'd5, 6'd1);
        push(1'b1, 8'h12, 64'h30, 64'h40, 6'd6, 6'd2);
        tick();
        chk("s1_both_valid", issue_valid, 2'b11);
        tick();
        chk("s1_empty", issue_valid, 0);
        chk("s1_not_full", rs_full, 0);

        // CDB wakeup then issue one cycle later
        alloc(0, 8'h21, 6'd10, 6'd3, 6'd9, 1'b0, 64'h0, 6'd7, 1'b1, 64'h77);
        push(1'b0, 8'h21, 64'hDEADBEEF, 64'h77, 6'd10, 6'd3);
        tick();
        chk("s2_waiting", issue_valid, 0);
        cdb(0, 6'd9, 32'hDEADBEEF);
        tick();
        chk("s2_issue", issue_valid, 2'b01);
        tick();
        chk("s2_empty", issue_valid, 0);

        // lane 1 blocked: lane 0 drains in allocation order
        issue_ready = 2'b01;
        alloc(0, 8'h31, 6'd20, 6'd4, 6'd1, 1'b1, 64'h1, 6'd1, 1'b1, 64'h2);
        alloc(1, 8'h32, 6'd21, 6'd5, 6'd1, 1'b1, 64'h3, 6'd1, 1'b1, 64'h4);
        push(1'b0, 8'h31, 64'h1, 64'h2, 6'd20, 6'd4);
        push(1'b0, 8'h32, 64'h3, 64'h4, 6'd21, 6'd5);
        push(1'b0, 8'h33, 64'h5, 64'h6, 6'd22, 6'd6);
        tick();
        chk("s3_first", issue_valid, 2'b11);
        alloc(0, 8'h33, 6'd22, 6'd6, 6'd1, 1'b1, 64'h5, 6'd1, 1'b1, 64'h6);
        tick();
        chk("s3_second", issue_valid, 2'b11);
        tick();
        chk("s3_third", issue_valid, 2'b01);
        tick();
        chk("s3_empty", issue_valid, 0);
        issue_ready = 2'b11;

        // fill all 16 entries with waiting ops
        for (int c = 0; c < 8; c++) begin
            chk("s4_not_full", rs_full, 0);
            for (int l = 0; l < 2; l++)
                alloc(l, 8'(64 + 2*c + l), 6'(2*c + l), 6'(2*c + l), 6'(40 + 2*c + l), 1'b0, 64'h0, 6'd1, 1'b1, 64'h5);
            tick();
        end
        chk("s4_full", rs_full, 1);
        push(1'b0, 8'h43, 64'h100, 64'h5, 6'd3, 6'd3);
        cdb(0, 6'd43, 32'h100);
        tick();
        chk("s4_one_issue", issue_valid, 2'b01);
        chk("s4_full_on_issue", rs_full, 1);
        tick();
        chk("s4_still_full", rs_full, 1);
        chk("s4_idle", issue_valid, 0);
        push(1'b0, 8'h44, 64'h200, 64'h5, 6'd4, 6'd4);
        push(1'b1, 8'h45, 64'h300, 64'h5, 6'd5, 6'd5);
        cdb(0, 6'd44, 32'h200);
        cdb(1, 6'd45, 32'h300);
        tick();
        chk("s4_two_issue", issue_valid, 2'b11);
        chk("s4_full_before", rs_full, 1);
        tick();
        chk("s4_released", rs_full, 0);

        // flush clears everything, including same-cycle allocations
        flush = 1'b1;
        tick();
        chk("s5_cleared_full", rs_full, 0);
        chk("s5_cleared_valid", issue_valid, 0);
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < 2; l++)
                alloc(l, 8'h50, 6'd0, 6'd0, 6'(50 + 2*c + l), 1'b0, 64'h0, 6'd1, 1'b1, 64'h5);
            tick();
        end
        flush = 1'b1;
        alloc(0, 8'h60, 6'd1, 6'd1, 6'd1, 1'b1, 64'h1, 6'd1, 1'b1, 64'h1);
        alloc(1, 8'h61, 6'd2, 6'd2, 6'd1, 1'b1, 64'h1, 6'd1, 1'b1, 64'h1);
        tick();
        chk("s5_flush_valid", issue_valid, 0);
        chk("s5_flush_full", rs_full, 0);
        cdb(0, 6'd50, 32'h1);
        cdb(1, 6'd51, 32'h2);
        tick();
        chk("s5_no_ghost", issue_valid, 0);
        tick();
        chk("s5_no_ghost2", issue_valid, 0);

        // both CDB ports carry the same tag: port 1 value wins
        alloc(0, 8'h70, 6'd30, 6'd7, 6'd1, 1'b1, 64'h1, 6'd12, 1'b0, 64'h0);
        push(1'b0, 8'h70, 64'h1, 64'h2222, 6'd30, 6'd7);
        tick();
        cdb(0, 6'd12, 32'h1111);
        cdb(1, 6'd12, 32'h2222);
        tick();
        chk("s6_issue", issue_valid, 2'b01);
        tick();
        chk("s6_once", issue_valid, 0);

        // wakeup on the allocation port in the same cycle
        alloc(1, 8'h71, 6'd31, 6'd8, 6'd13, 1'b0, 64'h0, 6'd1, 1'b1, 64'h3);
        cdb(1, 6'd13, 32'hCAFE);
        push(1'b0, 8'h71, 64'hCAFE, 64'h3, 6'd31, 6'd8);
        tick();
        chk("s7_alloc_wake", issue_valid, 2'b01);
        tick();

        // asynchronous reset mid-operation
        issue_ready = 2'b00;
        alloc(0, 8'h80, 6'd1, 6'd1, 6'd1, 1'b1, 64'h1, 6'd1, 1'b1, 64'h1);
        alloc(1, 8'h81, 6'd2, 6'd2, 6'd1, 1'b1, 64'h1, 6'd1, 1'b1, 64'h1);
        tick();
        chk("s8_pending", issue_valid, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("s8_async_valid", issue_valid, 0);
        chk("s8_async_full", rs_full, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        issue_ready = 2'b11;
        tick();
        chk("s8_empty", issue_valid, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
